// File: rtl/dist_ram_mp.sv
// Multi-read-port distributed RAM: one byte-enabled write port, NUM_READ_PORTS read ports,
// optional registered reads, and a sequential clear engine that zeroes the array.
//   state | meaning
//   IDLE  | user reads/writes serviced
//   CLEAR | one word zeroed per cycle at cnt, reads forced to 0, user writes dropped
module dist_ram_mp #(
  parameter int DATA_WIDTH     = 8,
  parameter int DATA_DEPTH     = 32,
  parameter int ADDRESS_WIDTH  = 5,
  parameter int NUM_READ_PORTS = 2,
  parameter int BYTE_WIDTH     = 8,
  parameter int READ_LATENCY   = 0,
  parameter int WRITE_FIRST    = 1
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [ADDRESS_WIDTH-1:0]                in_addr,
  input  logic [DATA_WIDTH-1:0]                   data_in,
  input  logic                                    write_en,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]        byte_en,
  input  logic [NUM_READ_PORTS*ADDRESS_WIDTH-1:0] out_addr,
  output logic [NUM_READ_PORTS*DATA_WIDTH-1:0]    data_out,
  input  logic                                    clear_req,
  output logic                                    busy
);

  localparam int NB = DATA_WIDTH / BYTE_WIDTH;
  localparam int IW = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
  localparam logic [ADDRESS_WIDTH:0] DEPTH_W = (ADDRESS_WIDTH + 1)'(DATA_DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_DEPTH - 1);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];

  logic                  wr_ok;
  logic [IW-1:0]         wr_idx;
  logic [DATA_WIDTH-1:0] wr_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (cnt_q == LAST_IDX) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    busy = (state_q == CLEAR);
  end

  // Merged word is shared by the array write and the write-first read bypass.
  always_comb begin
    wr_ok   = write_en && (state_q == IDLE) && ({1'b0, in_addr} < DEPTH_W);
    wr_idx  = in_addr[IW-1:0];
    wr_word = mem[wr_idx];
    for (int i = 0; i < NB; i++) begin
      if (byte_en[i]) wr_word[i*BYTE_WIDTH +: BYTE_WIDTH] = data_in[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == CLEAR) mem[cnt_q] <= '0;
    else if (wr_ok)       mem[wr_idx] <= wr_word;
  end

  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_rd
    logic [ADDRESS_WIDTH-1:0] ra;
    logic                     rd_ok;
    logic [DATA_WIDTH-1:0]    rd_word;

    assign ra      = out_addr[p*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign rd_ok   = (state_q == IDLE) && ({1'b0, ra} < DEPTH_W);
    assign rd_word = mem[ra[IW-1:0]];

    if (READ_LATENCY == 0) begin : g_comb
      assign data_out[p*DATA_WIDTH +: DATA_WIDTH] = rd_ok ? rd_word : '0;
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] rd_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                         rd_q <= '0;
        else if (!rd_ok)                                    rd_q <= '0;
        else if ((WRITE_FIRST != 0) && wr_ok && ra == in_addr) rd_q <= wr_word;
        else                                                rd_q <= rd_word;
      end
      assign data_out[p*DATA_WIDTH +: DATA_WIDTH] = rd_q;
    end
  end

endmodule

// File: tb/tb_dist_ram_mp.sv
// Bench for dist_ram_mp: three instances (comb read, registered write-first, registered
// read-first) share one stimulus stream and are checked against an array-based model.
module tb_dist_ram_mp;
  localparam int DW = 32, AW = 6, DEPTH = 32, NP = 2, NB = 4;

  logic clk = 1'b0, rst_n = 1'b1;
  logic [AW-1:0]    in_addr = '0;
  logic [DW-1:0]    data_in = '0;
  logic             write_en = 1'b0, clear_req = 1'b0;
  logic [NB-1:0]    byte_en = '0;
  logic [NP*AW-1:0] out_addr = '0;
  logic [NP*DW-1:0] do_l0, do_wf, do_rf;
  logic             busy_l0, busy_wf, busy_rf;

  always #5 clk = ~clk;

  dist_ram_mp #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .ADDRESS_WIDTH(AW), .NUM_READ_PORTS(NP),
                .BYTE_WIDTH(8), .READ_LATENCY(0), .WRITE_FIRST(1)) u_l0 (
    .clk(clk), .rst_n(rst_n), .in_addr(in_addr), .data_in(data_in), .write_en(write_en),
    .byte_en(byte_en), .out_addr(out_addr), .data_out(do_l0), .clear_req(clear_req), .busy(busy_l0));
  dist_ram_mp #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .ADDRESS_WIDTH(AW), .NUM_READ_PORTS(NP),
                .BYTE_WIDTH(8), .READ_LATENCY(1), .WRITE_FIRST(1)) u_wf (
    .clk(clk), .rst_n(rst_n), .in_addr(in_addr), .data_in(data_in), .write_en(write_en),
    .byte_en(byte_en), .out_addr(out_addr), .data_out(do_wf), .clear_req(clear_req), .busy(busy_wf));
  dist_ram_mp #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .ADDRESS_WIDTH(AW), .NUM_READ_PORTS(NP),
                .BYTE_WIDTH(8), .READ_LATENCY(1), .WRITE_FIRST(0)) u_rf (
    .clk(clk), .rst_n(rst_n), .in_addr(in_addr), .data_in(data_in), .write_en(write_en),
    .byte_en(byte_en), .out_addr(out_addr), .data_out(do_rf), .clear_req(clear_req), .busy(busy_rf));

  int n_assert = 0, n_fail = 0;
  logic [DW-1:0] m_mem [DEPTH];
  int            clr_left = DEPTH;
  logic [DW-1:0] exp_wf [NP];
  logic [DW-1:0] exp_rf [NP];

  function automatic logic [DW-1:0] m_read(logic [AW-1:0] a);
    if (clr_left > 0 || int'(a) >= DEPTH) return '0;
    return m_mem[a[4:0]];
  endfunction

  function automatic logic [DW-1:0] merge(logic [DW-1:0] old, logic [DW-1:0] d, logic [NB-1:0] be);
    for (int i = 0; i < NB; i++) if (be[i]) old[i*8 +: 8] = d[i*8 +: 8];
    return old;
  endfunction

  task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [AW-1:0] a;
    chk("busy_l0", 32'(busy_l0), 32'(clr_left > 0));
    chk("busy_wf", 32'(busy_wf), 32'(clr_left > 0));
    chk("busy_rf", 32'(busy_rf), 32'(clr_left > 0));
    for (int p = 0; p < NP; p++) begin
      a = out_addr[p*AW +: AW];
      chk($sformatf("rd_l0_p%0d@%0d", p, a), do_l0[p*DW +: DW], m_read(a));
      chk($sformatf("rd_wf_p%0d", p), do_wf[p*DW +: DW], exp_wf[p]);
      chk($sformatf("rd_rf_p%0d", p), do_rf[p*DW +: DW], exp_rf[p]);
    end
  endtask

  // Predict from pre-edge model state, advance the model, then compare 1 unit after the edge.
  task automatic cycle();
    logic [AW-1:0] a;
    logic [DW-1:0] old;
    for (int p = 0; p < NP; p++) begin
      a   = out_addr[p*AW +: AW];
      old = m_read(a);
      exp_rf[p] = old;
      exp_wf[p] = (old == old && clr_left == 0 && int'(a) < DEPTH && write_en && a == in_addr)
                  ? merge(old, data_in, byte_en) : old;
    end
    if (clr_left > 0) begin
      m_mem[DEPTH - clr_left] = '0;
      clr_left--;
    end else begin
      if (write_en && int'(in_addr) < DEPTH)
        m_mem[in_addr[4:0]] = merge(m_mem[in_addr[4:0]], data_in, byte_en);
      if (clear_req) clr_left = DEPTH;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    clr_left = DEPTH;
    for (int p = 0; p < NP; p++) begin
      exp_wf[p] = '0;
      exp_rf[p] = '0;
    end
    #3;
    check_all();
    #3;
    rst_n = 1'b1;
  endtask

  task automatic set_wr(int a, logic [DW-1:0] d, logic [NB-1:0] be);
    write_en = 1'b1;
    in_addr  = AW'(a);
    data_in  = d;
    byte_en  = be;
  endtask

  task automatic set_rd(int a0, int a1);
    out_addr = {AW'(a1), AW'(a0)};
  endtask

  task automatic rand_in();
    write_en = 1'($urandom_range(0, 1));
    in_addr  = AW'($urandom_range(0, 39));
    data_in  = $urandom;
    byte_en  = NB'($urandom);
    for (int p = 0; p < NP; p++)
      out_addr[p*AW +: AW] = ($urandom_range(0, 9) < 3) ? in_addr : AW'($urandom_range(0, 39));
  endtask

  task automatic run_clear(int req_at, int rst_at, output int n);
    n = 0;
    while (busy_l0 && n < 80) begin
      rand_in();
      clear_req = (n == req_at);
      if (n == rst_at) do_reset();
      cycle();
      n++;
    end
    clear_req = 1'b0;
  endtask

  task automatic sweep_zero();
    write_en = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      set_rd(a, DEPTH - 1 - a);
      cycle();
      chk("sweep_zero_p0", do_l0[DW-1:0], '0);
      chk("sweep_zero_p1", do_wf[2*DW-1:DW], '0);
    end
  endtask

  task automatic fill_and_start_clear();
    for (int a = 0; a < DEPTH; a++) begin
      set_wr(a, $urandom, 4'hF);
      cycle();
    end
    write_en  = 1'b0;
    clear_req = 1'b1;
    cycle();
    clear_req = 1'b0;
  endtask

  initial begin
    int n;
    #1;
    do_reset();
    run_clear(-1, -1, n);
    chk("init_clear_len", 32'(n), 32'd32);
    sweep_zero();

    // byte-enable merge
    set_wr(1, 32'hAABBCCDD, 4'hF); cycle();
    set_wr(1, 32'h11223344, 4'h5); cycle();
    write_en = 1'b0; set_rd(1, 0); cycle();
    chk("byte_merge_l0", do_l0[DW-1:0], 32'hAA22CC44);
    chk("byte_merge_rf", do_rf[DW-1:0], 32'hAA22CC44);

    // independent ports, shared address
    set_wr(1, 32'hAB, 4'hF); cycle();
    set_wr(2, 32'hFE, 4'hF); cycle();
    write_en = 1'b0; set_rd(1, 2); cycle();
    chk("mp_p0", do_l0[DW-1:0], 32'hAB);
    chk("mp_p1", do_l0[2*DW-1:DW], 32'hFE);
    set_rd(2, 2); cycle();
    chk("mp_same_p0", do_wf[DW-1:0], 32'hFE);
    chk("mp_same_p1", do_wf[2*DW-1:DW], 32'hFE);

    // read during write
    set_wr(4, 32'h33, 4'hF); set_rd(4, 4); cycle();
    chk("rdw_wf", do_wf[DW-1:0], 32'h33);
    chk("rdw_rf_old", do_rf[DW-1:0], 32'h00);
    chk("rdw_l0_after", do_l0[DW-1:0], 32'h33);
    write_en = 1'b0; cycle();
    chk("rdw_rf_new", do_rf[DW-1:0], 32'h33);

    // blocked writes
    set_wr(3, 32'hDE, 4'hF); write_en = 1'b0; set_rd(3, 3); cycle(); cycle();
    chk("we0_dropped", do_l0[DW-1:0], 32'h0);
    set_wr(40, 32'h5A5A5A5A, 4'hF); set_rd(40, 8); cycle();
    chk("oob_l0", do_l0[DW-1:0], 32'h0);
    chk("oob_wf", do_wf[DW-1:0], 32'h0);
    write_en = 1'b0; set_rd(8, 40); cycle();
    chk("oob_read", do_rf[2*DW-1:DW], 32'h0);

    // clear request with ignored second request
    fill_and_start_clear();
    run_clear(10, -1, n);
    chk("clear_req_len", 32'(n), 32'd32);
    sweep_zero();

    // reset mid-clear restarts from address 0
    fill_and_start_clear();
    run_clear(-1, 10, n);
    chk("clear_rst_len", 32'(n), 32'd42);
    sweep_zero();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rand_in();
      clear_req = ($urandom_range(0, 39) == 0);
      cycle();
    end
    clear_req = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
